// File: rtl/systolic_array_nxn.sv
// systolic_array_nxn: NxN output-stationary systolic multiplier computing C = X*W, streamed in and out over valid/ready
module systolic_array_nxn #(
  parameter int N        = 4,
  parameter int BITWIDTH = 4,
  parameter int ACCWIDTH = 2*BITWIDTH + $clog2(N)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [BITWIDTH-1:0] data_in,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                signed_mode,
  input  logic                accumulate,
  output logic [ACCWIDTH-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                busy
);
  localparam int NN = N*N;
  localparam int IW = $clog2(NN);
  localparam int TW = $clog2(3*N-2);

  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_X, COMPUTE, DRAIN} state_t;

  state_t state_q, state_d;
  logic [IW-1:0] idx_q;
  logic [TW-1:0] t_q;
  logic sm_q, am_q;
  logic [BITWIDTH-1:0] w_q [NN];
  logic [BITWIDTH-1:0] x_q [NN];
  logic [BITWIDTH-1:0] a_q [NN];
  logic [BITWIDTH-1:0] b_q [NN];
  logic [BITWIDTH-1:0] a_in [NN];
  logic [BITWIDTH-1:0] b_in [NN];
  logic [BITWIDTH-1:0] row_feed [N];
  logic [BITWIDTH-1:0] col_feed [N];
  logic [ACCWIDTH-1:0] acc_q [NN];
  logic beat, out_beat, idx_last, t_last;

  // product is exact in 2*BITWIDTH bits for either signedness, then extended per mode
  function automatic logic [ACCWIDTH-1:0] mul(input logic [BITWIDTH-1:0] a, input logic [BITWIDTH-1:0] b, input logic s);
    logic [2*BITWIDTH-1:0] p;
    p = {{BITWIDTH{s & a[BITWIDTH-1]}}, a} * {{BITWIDTH{s & b[BITWIDTH-1]}}, b};
    return {{(ACCWIDTH-2*BITWIDTH){s & p[2*BITWIDTH-1]}}, p};
  endfunction

  assign beat     = in_valid & in_ready;
  assign out_beat = out_valid & out_ready;
  assign idx_last = idx_q == IW'(NN-1);
  assign t_last   = t_q == TW'(3*N-3);

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (beat) state_d = LOAD_W;
      LOAD_W:  if (beat && idx_last) state_d = LOAD_X;
      LOAD_X:  if (beat && idx_last) state_d = COMPUTE;
      COMPUTE: if (t_last) state_d = DRAIN;
      DRAIN:   if (out_beat && idx_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = reset_n & (state_q inside {IDLE, LOAD_W, LOAD_X});
    busy      = state_q != IDLE;
    out_valid = state_q == DRAIN;
    out_last  = out_valid & idx_last;
    out_data  = out_valid ? acc_q[idx_q] : '0;
  end

  // skewed edge feed: row i / column j lag by i / j cycles
  always_comb begin
    for (int i = 0; i < N; i++) begin
      row_feed[i] = '0;
      col_feed[i] = '0;
      for (int k = 0; k < N; k++)
        if (int'(t_q) == i + k) begin
          row_feed[i] = x_q[i*N+k];
          col_feed[i] = w_q[k*N+i];
        end
      a_in[i*N] = row_feed[i];
      b_in[i]   = col_feed[i];
      for (int j = 1; j < N; j++) begin
        a_in[i*N+j] = a_q[i*N+j-1];
        b_in[j*N+i] = b_q[(j-1)*N+i];
      end
    end
  end

  // one index serves W load (IDLE beat is W[0][0]), X load and drain
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx_q <= '0;
      t_q   <= '0;
      sm_q  <= 1'b0;
      am_q  <= 1'b0;
      for (int k = 0; k < NN; k++) begin
        w_q[k]   <= '0;
        x_q[k]   <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        acc_q[k] <= '0;
      end
    end else begin
      if (beat && state_q == IDLE) begin
        sm_q <= signed_mode;
        am_q <= accumulate;
      end
      if (beat && state_q != LOAD_X) w_q[idx_q] <= data_in;
      if (beat && state_q == LOAD_X) x_q[idx_q] <= data_in;
      if (beat || out_beat) idx_q <= idx_last ? '0 : idx_q + 1'b1;
      if (beat && state_q == LOAD_X && idx_last) begin
        t_q <= '0;
        for (int k = 0; k < NN; k++) begin
          a_q[k] <= '0;
          b_q[k] <= '0;
          if (!am_q) acc_q[k] <= '0;
        end
      end
      if (state_q == COMPUTE) begin
        t_q <= t_q + 1'b1;
        for (int k = 0; k < NN; k++) begin
          a_q[k]   <= a_in[k];
          b_q[k]   <= b_in[k];
          acc_q[k] <= acc_q[k] + mul(a_in[k], b_in[k], sm_q);
        end
      end
    end
  end
endmodule

// File: tb/tb_systolic_array_nxn.sv
// tb_systolic_array_nxn: directed checks of the 4x4 systolic multiplier against hand-computed results
module tb_systolic_array_nxn;
  logic clk = 0, reset_n = 0, in_valid = 0, signed_mode = 0, accumulate = 0, out_ready = 0;
  logic [3:0] data_in = '0;
  logic in_ready, out_valid, out_last, busy;
  logic [9:0] out_data;
  int checks = 0, failures = 0;
  logic [3:0] w_id [16], w_f [16], x_seq [16], x_one [16], x_f [16];
  logic [9:0] e_seq [16], e_dbl [16], e_m4 [16], e_60 [16], e_900 [16], e_4 [16];

  systolic_array_nxn #(.N(4), .BITWIDTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready),
    .signed_mode(signed_mode), .accumulate(accumulate), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // modes are flipped after the first beat; only the first-beat values may take effect
  task automatic load(input logic [3:0] w [16], input logic [3:0] x [16], input logic sm, input logic am, input logic gaps);
    for (int b = 0; b < 32; b++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 0;
        @(negedge clk);
      end
      chk("in_ready_load", in_ready, 1);
      data_in     = b < 16 ? w[b] : x[b-16];
      in_valid    = 1;
      signed_mode = b == 0 ? sm : ~sm;
      accumulate  = b == 0 ? am : ~am;
      @(negedge clk);
    end
    in_valid = 0;
  endtask

  task automatic collect(input logic [9:0] e [16], input logic pat);
    int cyc = 0;
    int pi = 0;
    logic r;
    chk("busy_compute", busy, 1);
    chk("in_ready_compute", in_ready, 0);
    in_valid = 1;
    data_in  = 4'hF;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    in_valid = 0;
    chk("latency", cyc, 10);
    for (int k = 0; k < 16; k++) begin
      do begin
        r = pat ? (pi % 3 == 0) : 1'b1;
        pi++;
        out_ready = r;
        chk("out_valid", out_valid, 1);
        chk("out_data", out_data, e[k]);
        chk("out_last", out_last, k == 15);
        @(negedge clk);
      end while (!r);
    end
    out_ready = 0;
    chk("out_valid_end", out_valid, 0);
    chk("busy_end", busy, 0);
    chk("in_ready_end", in_ready, 1);
  endtask

  task automatic pulse_reset();
    reset_n = 0;
    @(negedge clk);
    chk("in_ready_in_reset", in_ready, 0);
    reset_n = 1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_last", out_last, 0);
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    for (int k = 0; k < 16; k++) begin
      w_id[k]  = (k / 4 == k % 4) ? 4'h1 : 4'h0;
      w_f[k]   = 4'hF;
      x_seq[k] = 4'(k);
      x_one[k] = 4'h1;
      x_f[k]   = 4'hF;
      e_seq[k] = 10'(k);
      e_dbl[k] = 10'(2*k);
      e_m4[k]  = 10'h3FC;
      e_60[k]  = 10'd60;
      e_900[k] = 10'd900;
      e_4[k]   = 10'd4;
    end
    repeat (2) @(negedge clk);
    chk("in_ready_in_reset", in_ready, 0);
    reset_n = 1;
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_last", out_last, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_busy", busy, 0);
    @(negedge clk);
    load(w_id, x_seq, 0, 0, 0);
    collect(e_seq, 0);
    load(w_f, x_one, 1, 0, 0);
    collect(e_m4, 0);
    load(w_f, x_one, 0, 0, 0);
    collect(e_60, 0);
    load(w_f, x_f, 0, 0, 0);
    collect(e_900, 0);
    load(w_f, x_f, 1, 0, 0);
    collect(e_4, 0);
    load(w_id, x_seq, 0, 0, 0);
    collect(e_seq, 0);
    load(w_id, x_seq, 0, 1, 0);
    collect(e_dbl, 0);
    load(w_id, x_seq, 0, 0, 0);
    collect(e_seq, 0);
    load(w_id, x_seq, 0, 0, 1);
    collect(e_seq, 1);
    load(w_id, x_seq, 0, 0, 0);
    repeat (3) @(negedge clk);
    pulse_reset();
    load(w_id, x_seq, 0, 0, 0);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("drain_reached", out_valid, 1);
    out_ready = 1;
    repeat (3) @(negedge clk);
    out_ready = 0;
    pulse_reset();
    load(w_id, x_seq, 0, 1, 0);
    collect(e_seq, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
